hex_operand_entry: RTL

Sequential front end that turns single hex key presses into the byte-wide write strobes consumed by the two-operand memory of the 8-bit hex adder. Debounces a raw key-valid level and assembles two nibbles (high first) into one byte. Issues a one-cycle write pulse and alternates the target operand slot after every commit. Sits between the board key/switch inputs and the operand memory's `input8`/`selector`/`activate` inputs.

---
 rtl/hex_operand_entry_if.sv | 21 ++
 rtl/hex_operand_entry.sv | 128 ++++++++++++
 2 files changed

// File: rtl/hex_operand_entry_if.sv
// Key-entry side and operand-memory write side of hex_operand_entry.
// master = the entry block (drives the memory write); slave = its environment.
interface hex_operand_entry_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] input8;
    logic       selector;
    logic       activate;
    logic       pending;
    logic       timeout;

    modport master (
        input  key_valid, key_code,
        output input8, selector, activate, pending, timeout
    );

    modport slave (
        output key_valid, key_code,
        input  input8, selector, activate, pending, timeout
    );
endinterface

// File: rtl/hex_operand_entry.sv
// Debounced two-nibble hex entry producing operand-memory writes; ENTRY_TIMEOUT_EN adds partial-entry abandon.
// Latency: pending/input8 one cycle after accept, activate one cycle after input8, selector toggles after activate.
// Backpressure: none; accepts are spaced by debounce press+release, the memory write is a fire-and-forget strobe.
module hex_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 16
`ifdef ENTRY_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    hex_operand_entry_if.master  bus
);

    typedef enum logic [1:0] {WAIT_HI, WAIT_LO, COMMIT} entryState_t;

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    entryState_t state;
    logic        debLevel;
    logic [7:0]  debCount;
    logic        accept;
    logic [3:0]  hiReg;
    logic [7:0]  input8Q;
    logic        selectorQ;
    logic        activateQ;
    logic        pendingQ;
    logic        timeoutQ;

    // Accept fires in the cycle the rising edge of the debounced level is decided,
    // so key_code is captured alongside it.
    assign accept = bus.key_valid && !debLevel && (debCount == DEB_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            debLevel <= 1'b0;
            debCount <= 8'd0;
        end else if (bus.key_valid == debLevel) begin
            debCount <= 8'd0;
        end else if (debCount == DEB_LAST) begin
            debLevel <= ~debLevel;
            debCount <= 8'd0;
        end else begin
            debCount <= debCount + 8'd1;
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idleCount;
    logic              idleExpired;

    assign idleExpired = (idleCount == IDLE_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            idleCount <= '0;
        end else if (state != WAIT_LO || accept || idleExpired) begin
            idleCount <= '0;
        end else begin
            idleCount <= idleCount + 1'b1;
        end
    end
`else
    assign timeoutQ = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= WAIT_HI;
            hiReg     <= 4'h0;
            input8Q   <= 8'h00;
            selectorQ <= 1'b0;
            activateQ <= 1'b0;
            pendingQ  <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
            timeoutQ  <= 1'b0;
`endif
        end else begin
            activateQ <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
            timeoutQ  <= 1'b0;
`endif
            // Slot flips only once the write strobe has completed.
            if (activateQ) begin
                selectorQ <= ~selectorQ;
            end
            case (state)
                WAIT_HI: begin
                    if (accept) begin
                        hiReg    <= bus.key_code;
                        pendingQ <= 1'b1;
                        state    <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (accept) begin
                        input8Q  <= {hiReg, bus.key_code};
                        pendingQ <= 1'b0;
                        state    <= COMMIT;
                    end
`ifdef ENTRY_TIMEOUT_EN
                    else if (idleExpired) begin
                        pendingQ <= 1'b0;
                        timeoutQ <= 1'b1;
                        state    <= WAIT_HI;
                    end
`endif
                end
                COMMIT: begin
                    activateQ <= 1'b1;
                    state     <= WAIT_HI;
                end
                default: state <= WAIT_HI;
            endcase
        end
    end

    assign bus.input8   = input8Q;
    assign bus.selector = selectorQ;
    assign bus.activate = activateQ;
    assign bus.pending  = pendingQ;
    assign bus.timeout  = timeoutQ;

endmodule
